// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem requester and
// a small instruction/PC buffer feeding decode over valid/ready.
`timescale 1ns / 1ps

module fetch_unit #(
    parameter int unsigned             DataWidth = 32,
    parameter logic [DataWidth-1:0]    ResetPc   = '0,
    parameter int unsigned             FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 imem_req_o,
    output logic [DataWidth-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DataWidth-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [DataWidth-1:0] redirect_pc_i,
    output logic                 instr_valid_o,
    output logic [DataWidth-1:0] instr_o,
    output logic [DataWidth-1:0] instr_pc_o,
    input  logic                 instr_ready_i
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop
    } state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   pc_q, pc_d;
    logic [DataWidth-1:0]   req_pc_q, req_pc_d;
    logic                   req_en_q;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [DataWidth-1:0]   fifo_instr_q [FifoDepth];
    logic [DataWidth-1:0]   fifo_pc_q    [FifoDepth];

    logic                   req;
    logic                   push;
    logic                   pop;
    logic                   unused_redirect_lsb;

    // Redirect targets are forced word aligned; the low bits are ignored.
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Issue only from IDLE with a guaranteed free slot for the response.
    assign req  = req_en_q && (state_q == StIdle) && (cnt_q < CntW'(FifoDepth)) && !redirect_i;
    assign push = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    assign pop  = (cnt_q != '0) && instr_ready_i && !redirect_i;

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (cnt_q != '0);
    assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q] : '0;

    // Next-state: fetch FSM, PC and request bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[DataWidth-1:2], 2'b00};
            unique case (state_q)
                StIdle:         state_d = StIdle;
                StWait, StDrop: state_d = imem_rvalid_i ? StIdle : StDrop;
                default:        state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && imem_gnt_i) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + DataWidth'(4);
                        state_d  = StWait;
                    end
                end
                StWait:  if (imem_rvalid_i) state_d = StIdle;
                StDrop:  if (imem_rvalid_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Next-state: buffer pointers and occupancy, flushed on redirect.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Control state registers; request enable rises one edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            pc_q     <= ResetPc;
            req_pc_q <= '0;
            req_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_en_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer storage; contents are only observed through the valid-gated outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, scoreboard of
// expected {pc, instr} pairs, and one task per scenario.
`timescale 1ns / 1ps

module tb_fetch_unit;

    localparam int unsigned DataWidth = 32;
    localparam logic [31:0] ResetPc   = 32'h0000_0080;
    localparam int unsigned FifoDepth = 2;

    logic        clk_i;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int          checks   = 0;
    int          failures = 0;
    int          pop_cnt  = 0;
    int          lat      = 1;
    int          lat_cnt  = 0;
    bit          outstanding = 0;
    bit          drop_pend   = 0;
    logic [31:0] pend_pc  = '0;
    logic [63:0] exp_q [$];

    fetch_unit #(
        .DataWidth (DataWidth),
        .ResetPc   (ResetPc),
        .FifoDepth (FifoDepth)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // Scoreboard: track grants/responses, predict pushes, check every pop.
    always @(posedge clk_i or negedge rst_ni) begin
        logic [63:0] exp;
        if (!rst_ni) begin
            exp_q.delete();
            outstanding = 0;
            drop_pend   = 0;
        end else begin
            if (redirect_i) begin
                exp_q.delete();
                drop_pend = outstanding;
            end else if (instr_valid_o && instr_ready_i) begin
                pop_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_pop: got pc=%h instr=%h, required no output",
                             instr_pc_o, instr_o);
                end else begin
                    exp = exp_q.pop_front();
                    if ({instr_pc_o, instr_o} !== exp) begin
                        failures++;
                        $display("FAIL sb_data: got pc=%h instr=%h, required pc=%h instr=%h",
                                 instr_pc_o, instr_o, exp[63:32], exp[31:0]);
                    end
                end
            end
            if (imem_rvalid_i && outstanding) begin
                if (!drop_pend && !redirect_i) exp_q.push_back({pend_pc, mem_data(pend_pc)});
                outstanding = 0;
                drop_pend   = 0;
            end
            if (imem_req_o && imem_gnt_i) begin
                checks++;
                if (outstanding || imem_addr_o[1:0] !== 2'b00) begin
                    failures++;
                    $display("FAIL sb_issue: got addr=%h outstanding=%0b, required aligned, none",
                             imem_addr_o, outstanding);
                end
                outstanding = 1;
                drop_pend   = 0;
                pend_pc     = imem_addr_o;
                lat_cnt     = lat;
            end
        end
    end

    // Memory responder: rvalid 'lat' cycles after the grant edge.
    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
            if (outstanding) begin
                if (lat_cnt <= 1) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_data(pend_pc);
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    task automatic test_reset;
        rst_ni = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b1; lat = 1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (imem_req_o !== 1'b0) begin
            failures++; $display("FAIL reset_req: got %0b, required 0", imem_req_o);
        end
        checks++;
        if ({instr_valid_o, instr_o, instr_pc_o} !== 65'd0) begin
            failures++;
            $display("FAIL reset_out: got v=%0b i=%h pc=%h, required zeros",
                     instr_valid_o, instr_o, instr_pc_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== ResetPc || instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got req=%0b addr=%h v=%0b, required 1 %h 0",
                     imem_req_o, imem_addr_o, instr_valid_o, ResetPc);
        end
    endtask

    task automatic test_stream;
        @(negedge clk_i); instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h84 || instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_c1: got req=%0b addr=%h v=%0b, required 0 84 0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h80 || instr_o !== mem_data(32'h80) ||
            imem_req_o !== 1'b1 || imem_addr_o !== 32'h84) begin
            failures++;
            $display("FAIL stream_c2: got v=%0b pc=%h i=%h req=%0b addr=%h, required 1 80 %h 1 84",
                     instr_valid_o, instr_pc_o, instr_o, imem_req_o, imem_addr_o,
                     mem_data(32'h80));
        end
        @(posedge clk_i); #1;
        checks++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h88) begin
            failures++;
            $display("FAIL stream_c3: got v=%0b req=%0b addr=%h, required 0 0 88",
                     instr_valid_o, imem_req_o, imem_addr_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h84 || instr_o !== mem_data(32'h84) ||
            imem_req_o !== 1'b1 || imem_addr_o !== 32'h88) begin
            failures++;
            $display("FAIL stream_c4: got v=%0b pc=%h i=%h req=%0b addr=%h, required 1 84 %h 1 88",
                     instr_valid_o, instr_pc_o, instr_o, imem_req_o, imem_addr_o,
                     mem_data(32'h84));
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk_i); instr_ready_i = 1'b0;
        @(posedge clk_i);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h8C || instr_valid_o !== 1'b1 ||
                instr_pc_o !== 32'h84 || instr_o !== mem_data(32'h84)) begin
                failures++;
                $display("FAIL bp_full[%0d]: got req=%0b addr=%h v=%0b pc=%h, required 0 8c 1 84",
                         i, imem_req_o, imem_addr_o, instr_valid_o, instr_pc_o);
            end
        end
        @(negedge clk_i); instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8C || instr_valid_o !== 1'b1 ||
            instr_pc_o !== 32'h88) begin
            failures++;
            $display("FAIL bp_release: got req=%0b addr=%h v=%0b pc=%h, required 1 8c 1 88",
                     imem_req_o, imem_addr_o, instr_valid_o, instr_pc_o);
        end
    endtask

    task automatic test_gnt_stall;
        @(negedge clk_i); instr_ready_i = 1'b0; imem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8C) begin
                failures++;
                $display("FAIL gnt_hold[%0d]: got req=%0b addr=%h, required 1 8c",
                         i, imem_req_o, imem_addr_o);
            end
        end
        @(negedge clk_i); imem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h90) begin
            failures++;
            $display("FAIL gnt_accept: got req=%0b addr=%h, required 0 90",
                     imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect;
        int i;
        @(negedge clk_i); instr_ready_i = 1'b1; lat = 3;
        for (i = 0; i < 20 && imem_req_o !== 1'b1; i++) @(negedge clk_i);
        checks++;
        if (imem_req_o !== 1'b1) begin
            failures++; $display("FAIL redir_wait_req: got req=%0b, required 1", imem_req_o);
        end
        @(posedge clk_i);
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h203;
        @(posedge clk_i); #1;
        checks++;
        if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h200 || imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush: got v=%0b addr=%h req=%0b, required 0 200 0",
                     instr_valid_o, imem_addr_o, imem_req_o);
        end
        @(negedge clk_i); redirect_i = 1'b0; lat = 1;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200 || instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL redir_drop: got req=%0b addr=%h v=%0b, required 1 200 0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
        @(posedge clk_i);
        @(posedge clk_i); #1;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instr_o !== mem_data(32'h200)) begin
            failures++;
            $display("FAIL redir_first: got v=%0b pc=%h i=%h, required 1 200 %h",
                     instr_valid_o, instr_pc_o, instr_o, mem_data(32'h200));
        end
    endtask

    task automatic test_redirect_pop;
        int pop_before;
        @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h400;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_ready_i !== 1'b1) begin
            failures++;
            $display("FAIL rpop_setup: got v=%0b rdy=%0b, required 1 1", instr_valid_o,
                     instr_ready_i);
        end
        pop_before = pop_cnt;
        @(posedge clk_i); #1;
        checks++;
        if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h400 || pop_cnt !== pop_before) begin
            failures++;
            $display("FAIL rpop_flush: got v=%0b addr=%h pops=%0d, required 0 400 %0d",
                     instr_valid_o, imem_addr_o, pop_cnt, pop_before);
        end
        @(negedge clk_i); redirect_i = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin
            failures++;
            $display("FAIL rpop_req: got req=%0b addr=%h, required 1 400", imem_req_o,
                     imem_addr_o);
        end
    endtask

    task automatic test_async_reset;
        int i;
        @(negedge clk_i); instr_ready_i = 1'b0; lat = 3;
        for (i = 0; i < 20 && instr_valid_o !== 1'b1; i++) @(negedge clk_i);
        for (i = 0; i < 20 && imem_req_o !== 1'b1; i++) @(negedge clk_i);
        checks++;
        if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup: got v=%0b req=%0b, required 1 1", instr_valid_o,
                     imem_req_o);
        end
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({instr_valid_o, instr_o, instr_pc_o, imem_req_o} !== 66'd0) begin
            failures++;
            $display("FAIL arst_zero: got v=%0b i=%h pc=%h req=%0b, required zeros",
                     instr_valid_o, instr_o, instr_pc_o, imem_req_o);
        end
        @(negedge clk_i);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== ResetPc || instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL arst_restart: got req=%0b addr=%h v=%0b, required 1 %h 0",
                     imem_req_o, imem_addr_o, instr_valid_o, ResetPc);
        end
        @(negedge clk_i); instr_ready_i = 1'b1; lat = 1;
        for (i = 0; i < 20 && instr_valid_o !== 1'b1; i++) begin
            @(posedge clk_i); #1;
        end
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== ResetPc) begin
            failures++;
            $display("FAIL arst_first: got v=%0b pc=%h, required 1 %h", instr_valid_o,
                     instr_pc_o, ResetPc);
        end
    endtask

    task automatic test_random_ready;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            instr_ready_i = ($urandom_range(0, 2) != 0);
            lat = int'($urandom_range(1, 3));
        end
        @(negedge clk_i); instr_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_pop();
        test_async_reset();
        test_random_ready();
        repeat (4) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
